// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch sequencer. Holds a loadable instruction memory,
//            runs a program counter and presents one registered instruction
//            per unstalled cycle. Supports stall, zero-bubble branch redirect,
//            end-of-program detection and fault reporting.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            load_en/load_addr/load_data   - imem write port (not in RUN)
//            start, prog_len               - launch program from address 0
//            stall                         - freeze fetch state and outputs
//            branch_taken, branch_target   - redirect the current fetch
//            Instruction, pc, instr_valid  - registered fetch outputs
//            busy, done, fault             - state levels
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int WORD_WIDTH = 32,
  parameter int AW         = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [AW-1:0]         load_addr,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic                  start,
  input  logic [AW:0]           prog_len,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_target,
  output logic [WORD_WIDTH-1:0] Instruction,
  output logic [WORD_WIDTH-1:0] pc,
  output logic                  instr_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam int          c_DEPTH   = 2 ** AW;
  localparam logic [AW:0] c_DEPTH_W = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_imem [c_DEPTH];
  logic [AW:0]           r_len;
  logic [WORD_WIDTH-1:0] r_fetch_pc;

  logic [AW:0]           w_len_clamped;
  logic                  w_branch;
  logic [WORD_WIDTH-1:0] w_fetch_addr;
  logic [WORD_WIDTH-1:0] w_fetch_idx;
  logic [WORD_WIDTH-1:0] w_len_ext;
  logic                  w_out_of_range;
  logic                  w_misaligned;
  logic [AW-1:0]         w_imem_idx;

  assign w_len_clamped = (prog_len > c_DEPTH_W) ? c_DEPTH_W : prog_len;

  // A redirect only makes sense relative to a valid instruction on the outputs.
  assign w_branch     = branch_taken & instr_valid;
  assign w_fetch_addr = w_branch ? branch_target : r_fetch_pc;

  // Full-width range compare: any set upper bit is out of range, so addresses
  // beyond the program never alias back into imem.
  assign w_fetch_idx    = w_fetch_addr >> 2;
  assign w_len_ext      = {{(WORD_WIDTH-AW-1){1'b0}}, r_len};
  assign w_out_of_range = (w_fetch_idx >= w_len_ext);
  assign w_misaligned   = (w_fetch_addr[1:0] != 2'b00);
  assign w_imem_idx     = w_fetch_addr[AW+1:2];

  // Instruction memory: no reset, writable whenever no program is running.
  // A write on the start edge lands before the first fetch reads it.
  always_ff @(posedge clk) begin
    if (load_en && (r_state != S_RUN)) begin
      r_imem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_fetch_pc  <= '0;
      Instruction <= '0;
      pc          <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!stall) begin
            if (w_branch && (w_misaligned || w_out_of_range)) begin
              r_state     <= S_FAULT;
              instr_valid <= 1'b0;
            end else if (w_out_of_range) begin
              r_state     <= S_DONE;
              instr_valid <= 1'b0;
            end else begin
              Instruction <= r_imem[w_imem_idx];
              pc          <= w_fetch_addr;
              instr_valid <= 1'b1;
              r_fetch_pc  <= w_fetch_addr + WORD_WIDTH'(4);
            end
          end
        end
        default: begin
          // IDLE, DONE and FAULT all accept a new launch.
          if (start) begin
            r_len      <= w_len_clamped;
            r_fetch_pc <= '0;
            r_state    <= (w_len_clamped == '0) ? S_DONE : S_RUN;
          end
        end
      endcase
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign fault = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. Table-driven vectors
//            for run/stall/branch/fault sequences plus hand-written sequences
//            for load/start collision, length clamp, async reset, zero length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int W     = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  // Expected flag encoding: {instr_valid, busy, done, fault}
  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_RUNV = 4'b1100;
  localparam logic [3:0] F_RUN0 = 4'b0100;
  localparam logic [3:0] F_DONE = 4'b0010;
  localparam logic [3:0] F_FLT  = 4'b0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [W-1:0]  branch_target = '0;
  logic [W-1:0]  Instruction;
  logic [W-1:0]  pc;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic          fault;

  instr_fetch_unit #(.WORD_WIDTH(W), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .start         (start),
    .prog_len      (prog_len),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .Instruction   (Instruction),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic [AW:0]   len;
    logic          stl;
    logic          br;
    logic [W-1:0]  tgt;
    logic          ld;
    logic [AW-1:0] la;
    logic [W-1:0]  ldd;
    logic [W-1:0]  e_instr;
    logic [W-1:0]  e_pc;
    logic [3:0]    e_flags;
  } vec_t;

  typedef struct {
    logic [W-1:0] instr;
    logic [W-1:0] pc;
    logic [3:0]   flags;
  } exp_t;

  exp_t         sb[$];
  vec_t         vecs[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prog [5];

  function automatic vec_t mk(logic st, logic [AW:0] len, logic stl, logic br,
                              logic [W-1:0] tgt, logic ld, logic [AW-1:0] la,
                              logic [W-1:0] ldd, logic [W-1:0] ei,
                              logic [W-1:0] ep, logic [3:0] ef);
    vec_t v;
    v = '{st, len, stl, br, tgt, ld, la, ldd, ei, ep, ef};
    return v;
  endfunction

  function automatic vec_t st_row(logic [AW:0] len, logic [W-1:0] ei,
                                  logic [W-1:0] ep, logic [3:0] ef);
    return mk(1'b1, len, 1'b0, 1'b0, '0, 1'b0, '0, '0, ei, ep, ef);
  endfunction

  function automatic vec_t rn_row(logic stl, logic br, logic [W-1:0] tgt,
                                  logic [W-1:0] ei, logic [W-1:0] ep,
                                  logic [3:0] ef);
    return mk(1'b0, '0, stl, br, tgt, 1'b0, '0, '0, ei, ep, ef);
  endfunction

  task automatic compare(string name, exp_t e);
    checks++;
    if ({Instruction, pc, instr_valid, busy, done, fault} !== {e.instr, e.pc, e.flags}) begin
      errors++;
      $display("FAIL %s: got instr=%h pc=%h vbdf=%b, expected instr=%h pc=%h vbdf=%b",
               name, Instruction, pc, {instr_valid, busy, done, fault},
               e.instr, e.pc, e.flags);
    end
  endtask

  // Expectation is queued when the stimulus is driven, popped after the edge.
  task automatic step(string name, logic [W-1:0] ei, logic [W-1:0] ep, logic [3:0] ef);
    exp_t e;
    e = '{ei, ep, ef};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got instr=%h expected an entry", name, Instruction);
    end else begin
      compare(name, sb.pop_front());
    end
  endtask

  task automatic load_word(logic [AW-1:0] a, logic [W-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1;
    load_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    prog[0] = 32'h00A00A3B;
    prog[1] = 32'h00500ABB;
    prog[2] = 32'h014A8B33;
    prog[3] = 32'h01600CA3;
    prog[4] = 32'h01900C83;

    // Run with stall at pc=8; branch and load during stall/RUN ignored.
    vecs.push_back(st_row(7'd5, '0, '0, F_RUN0));
    vecs.push_back(rn_row(0, 0, '0, prog[0], 32'h0,  F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[1], 32'h4,  F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[2], 32'h8,  F_RUNV));
    vecs.push_back(rn_row(1, 0, '0, prog[2], 32'h8,  F_RUNV));
    vecs.push_back(rn_row(1, 1, 32'h6, prog[2], 32'h8, F_RUNV));
    vecs.push_back(mk(0, '0, 1, 0, '0, 1, 6'd1, 32'hFFFFFFFF, prog[2], 32'h8, F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[3], 32'hC,  F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[4], 32'h10, F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[4], 32'h10, F_DONE));
    vecs.push_back(rn_row(0, 0, '0, prog[4], 32'h10, F_DONE));
    // Branch back to 4 at pc=C; branch while instr_valid=0 ignored.
    vecs.push_back(st_row(7'd5, prog[4], 32'h10, F_RUN0));
    vecs.push_back(rn_row(0, 1, 32'h6, prog[0], 32'h0, F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[1], 32'h4,  F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[2], 32'h8,  F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[3], 32'hC,  F_RUNV));
    vecs.push_back(rn_row(0, 1, 32'h4, prog[1], 32'h4, F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[2], 32'h8,  F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[3], 32'hC,  F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[4], 32'h10, F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[4], 32'h10, F_DONE));
    // Misaligned target fault, out-of-range target fault, restart.
    vecs.push_back(st_row(7'd5, prog[4], 32'h10, F_RUN0));
    vecs.push_back(rn_row(0, 0, '0, prog[0], 32'h0, F_RUNV));
    vecs.push_back(rn_row(0, 1, 32'h6, prog[0], 32'h0, F_FLT));
    vecs.push_back(rn_row(0, 0, '0, prog[0], 32'h0, F_FLT));
    vecs.push_back(st_row(7'd5, prog[0], 32'h0, F_RUN0));
    vecs.push_back(rn_row(0, 0, '0, prog[0], 32'h0, F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[1], 32'h4, F_RUNV));
    vecs.push_back(rn_row(0, 1, 32'h14, prog[1], 32'h4, F_FLT));
    vecs.push_back(st_row(7'd5, prog[1], 32'h4, F_RUN0));
    vecs.push_back(rn_row(0, 0, '0, prog[0], 32'h0, F_RUNV));
    vecs.push_back(rn_row(0, 1, 32'h10, prog[4], 32'h10, F_RUNV));
    vecs.push_back(rn_row(0, 0, '0, prog[4], 32'h10, F_DONE));

    #2;
    compare("reset_values", '{32'h0, 32'h0, F_IDLE});
    #15;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) load_word(AW'(i), prog[i]);
    step("idle_after_load", 32'h0, 32'h0, F_IDLE);

    foreach (vecs[i]) begin
      start         = vecs[i].st;
      prog_len      = vecs[i].len;
      stall         = vecs[i].stl;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      load_en       = vecs[i].ld;
      load_addr     = vecs[i].la;
      load_data     = vecs[i].ldd;
      step($sformatf("vec[%0d]", i), vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_flags);
    end
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0; load_en = 1'b0;

    // Load and start on the same edge: the new word is the first fetch.
    load_en = 1'b1; load_addr = '0; load_data = 32'hDEADBEEF;
    start = 1'b1; prog_len = 7'd1;
    step("ld_start_edge", prog[4], 32'h10, F_RUN0);
    load_en = 1'b0; start = 1'b0;
    step("ld_start_first", 32'hDEADBEEF, 32'h0, F_RUNV);
    step("ld_start_done", 32'hDEADBEEF, 32'h0, F_DONE);

    // Length clamp: prog_len = DEPTH+1 issues exactly DEPTH instructions.
    for (int i = 0; i < DEPTH; i++) load_word(AW'(i), 32'hA5000000 + W'(i));
    start = 1'b1; prog_len = 7'(DEPTH + 1);
    step("clamp_start", 32'hDEADBEEF, 32'h0, F_RUN0);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      step($sformatf("clamp[%0d]", i), 32'hA5000000 + W'(i), W'(4 * i), F_RUNV);
    step("clamp_done", 32'hA500003F, 32'hFC, F_DONE);

    // Asynchronous reset between edges while pc=8.
    start = 1'b1; prog_len = 7'd5;
    step("rst_run_start", 32'hA500003F, 32'hFC, F_RUN0);
    start = 1'b0;
    step("rst_run_pc0", 32'hA5000000, 32'h0, F_RUNV);
    step("rst_run_pc4", 32'hA5000001, 32'h4, F_RUNV);
    step("rst_run_pc8", 32'hA5000002, 32'h8, F_RUNV);
    #2;
    rst_n = 1'b0;
    #1;
    compare("async_reset", '{32'h0, 32'h0, F_IDLE});
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step("idle_after_rst0", 32'h0, 32'h0, F_IDLE);
    step("idle_after_rst1", 32'h0, 32'h0, F_IDLE);

    // Zero-length program goes straight to DONE, never validating.
    start = 1'b1; prog_len = 7'd0;
    step("len0_start", 32'h0, 32'h0, F_DONE);
    start = 1'b0;
    step("len0_hold0", 32'h0, 32'h0, F_DONE);
    step("len0_hold1", 32'h0, 32'h0, F_DONE);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
